// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_pkg;

    localparam int unsigned SERIAL_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fs1.sv
// Single-bit full-subtractor cell: d = x - y - bi, bo = borrow out.
module fs1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, LSB first through one fs1 cell; result and borrow held until the next completion.
module serial_sub
    import serial_pkg::*;
#(
    parameter int unsigned N = SERIAL_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
);

    localparam int unsigned CW = $clog2(N) + 1;

    state_t         state, state_nxt;
    logic [N-1:0]   sa, sb, sr, sr_shift;
    logic           br;
    logic [CW-1:0]  cnt;
    logic           cell_d, cell_bo;
    logic           load, step, last;

    fs1 u_fs1 (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Written as a shift plus MSB overwrite so that N = 1 needs no zero-width slice.
    always_comb begin
        sr_shift        = sr >> 1;
        sr_shift[N-1]   = cell_d;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            // Flags are registered from the next state so they align with the state register.
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
            if (load) begin
                sa  <= a;
                sb  <= b;
                br  <= bin;
                sr  <= '0;
                cnt <= '0;
            end else if (step) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                sr  <= sr_shift;
                br  <= cell_bo;
                cnt <= cnt + CW'(1);
                if (last) begin
                    d    <= sr_shift;
                    bout <= cell_bo;
                end
            end
        end
    end

endmodule
